// File: rtl/rle_pkg.sv
// Shared definitions for the binary RLE frame sequencer.
//   - Default image geometry and run-length field width.
//   - Token field offsets for the default width. A token is laid out as
//     {eof, eol, bit, run_len[RUN_W-1:0]}, with run_len in the LSBs.
//   - Sequencer state encoding and a small width helper.
package rle_pkg;

  localparam int IMG_W_DEF      = 640;
  localparam int IMG_H_DEF      = 480;
  localparam int RUN_W_DEF      = 13;
  localparam int FIFO_DEPTH_DEF = 8;

  // Token bit positions when RUN_W == RUN_W_DEF.
  localparam int LEN_LSB = 0;
  localparam int BIT_B   = RUN_W_DEF;
  localparam int EOL_B   = RUN_W_DEF + 1;
  localparam int EOF_B   = RUN_W_DEF + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a pixel tagged with in_sop
    ST_RUN   = 2'd1,  // accumulating runs inside a frame
    ST_SPLIT = 2'd2   // writing the second token of a line-end split
  } seq_state_e;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rle_frame_sequencer_if.sv
// Pixel-in / token-out bus of the RLE frame sequencer.
//   in_valid/in_bit/in_sop  pixel stream from the classifier
//   in_ready                sequencer accepts a pixel
//   out_valid/out_data      token at the FIFO head
//   out_ready               consumer takes the token
// master: the pixel source and token consumer; slave: the sequencer.
interface rle_frame_sequencer_if
  import rle_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF
) ();

  logic             in_valid;
  logic             in_bit;
  logic             in_sop;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [RUN_W+2:0] out_data;

  modport master (
    output in_valid, in_bit, in_sop, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_bit, in_sop, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rle_token_fifo.sv
// First-word fall-through token FIFO.
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   wr_en/data  write port; a word written in cycle n is at rd_data in n+1
//   rd_en       pops the head when the FIFO is not empty
//   rd_data     current head word
//   count/free  registered occupancy and free entries
// A write while full is accepted only if a read happens in the same cycle.
// An empty FIFO has no bypass path, so the one-cycle latency always holds.
module rle_token_fifo #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CNT_W'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count alone, so
  // stale words are never presented and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state is updated with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      free   <= CNT_W'(DEPTH);
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10: begin
          count <= count + CNT_W'(1);
          free  <= free - CNT_W'(1);
        end
        2'b01: begin
          count <= count - CNT_W'(1);
          free  <= free + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rle_frame_sequencer.sv
// Frames a per-pixel bit stream into lines/frames and emits run tokens
// {eof, eol, bit, run_len}. Every run is closed at the end of each line.
//   clk, rst     clock, synchronous active-high reset
//   bus (slave)  pixel input with valid/ready/sop, token output valid/ready
//   frame_done   one-cycle pulse when the eof token is written
//   err_abort    one-cycle pulse when in_sop arrives inside a frame
// A line whose last pixel changes the bit needs two tokens; the second is
// parked in a pending register and written from SPLIT. Pixel intake stalls
// while fewer than two FIFO entries are free, so that pair always fits.
module rle_frame_sequencer
  import rle_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int RUN_W      = RUN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  rle_frame_sequencer_if.slave  bus,
  output logic                  frame_done,
  output logic                  err_abort
);

  localparam int X_W   = idx_w(IMG_W);
  localparam int Y_W   = idx_w(IMG_H);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TOK_W = RUN_W + 3;

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [RUN_W-1:0] run_q;
  logic             cur_bit_q;
  logic             pend_eof_q;
  logic             pend_bit_q;

  logic             accept;
  logic             restart;
  logic             last_px;
  logic             last_line;
  logic             same_bit;
  logic             fresh_run;
  logic             wr_en;
  logic [TOK_W-1:0] wr_data;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_free;

  assign bus.in_ready = !rst && (state_q != ST_SPLIT) && (fifo_free >= CNT_W'(2));
  assign accept       = bus.in_valid && bus.in_ready;
  // in_sop restarts the frame from any state that can accept a pixel.
  assign restart      = accept && bus.in_sop;
  assign last_px      = (x_q == X_W'(IMG_W - 1));
  assign last_line    = (y_q == Y_W'(IMG_H - 1));
  assign same_bit     = (bus.in_bit == cur_bit_q);
  // run_q == 0 marks the first pixel of a line: it opens a run, no token.
  assign fresh_run    = (run_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (restart) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && !bus.in_sop && !fresh_run && last_px) begin
          if (!same_bit)      state_d = ST_SPLIT;
          else if (last_line) state_d = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        state_d = pend_eof_q ? ST_IDLE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: token writes and the abort pulse.
  always_comb begin
    wr_en     = 1'b0;
    wr_data   = '0;
    err_abort = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (bus.in_sop) begin
            err_abort = 1'b1;
          end else if (!fresh_run) begin
            if (!same_bit) begin
              // A bit change closes the open run; on the last pixel the
              // new one-pixel run follows from SPLIT.
              wr_en   = 1'b1;
              wr_data = {1'b0, 1'b0, cur_bit_q, run_q};
            end else if (last_px) begin
              wr_en   = 1'b1;
              wr_data = {last_line, 1'b1, cur_bit_q, run_q + RUN_W'(1)};
            end
          end
        end
      end
      ST_SPLIT: begin
        wr_en   = 1'b1;
        wr_data = {pend_eof_q, 1'b1, pend_bit_q, RUN_W'(1)};
      end
      default: ;
    endcase
  end

  assign frame_done = wr_en && wr_data[TOK_W-1];

  // Position counters, open run and pending split token.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      run_q      <= '0;
      cur_bit_q  <= 1'b0;
      pend_eof_q <= 1'b0;
      pend_bit_q <= 1'b0;
    end else if (restart) begin
      // Abandons any partial frame; tokens already written stay queued.
      x_q       <= X_W'(1);
      y_q       <= '0;
      cur_bit_q <= bus.in_bit;
      run_q     <= RUN_W'(1);
    end else if (state_q == ST_RUN && accept) begin
      if (last_px) begin
        x_q        <= '0;
        y_q        <= last_line ? '0 : y_q + Y_W'(1);
        run_q      <= '0;
        pend_eof_q <= last_line;
        pend_bit_q <= bus.in_bit;
      end else begin
        x_q <= x_q + X_W'(1);
        if (fresh_run || !same_bit) begin
          cur_bit_q <= bus.in_bit;
          run_q     <= RUN_W'(1);
        end else begin
          run_q <= run_q + RUN_W'(1);
        end
      end
    end
  end

  rle_token_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (bus.out_ready),
    .rd_data (bus.out_data),
    .count   (fifo_count),
    .free    (fifo_free)
  );

  assign bus.out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_rle_frame_sequencer.sv
// Directed bench for rle_frame_sequencer with an 8x2 image and 8-entry FIFO.
// Expected tokens are queued as stimulus is issued; a monitor pops and
// compares each token the DUT hands over.
module tb_rle_frame_sequencer;
  import rle_pkg::*;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int RW = 13;

  typedef struct {
    logic [RW+2:0] tok;
    bit            fresh;  // start a new line-sum accumulation here
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic frame_done;
  logic err_abort;

  rle_frame_sequencer_if #(.RUN_W(RW)) bus ();

  rle_frame_sequencer #(
    .IMG_W      (W),
    .IMG_H      (H),
    .RUN_W      (RW),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .err_abort  (err_abort)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_count = 0;
  int   fd_cycle = -1;
  int   ab_count = 0;
  int   rdy_low = 0;
  int   eof_pop_cycle = -1;
  int   line_sum = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW+2:0] tok(input logic e, input logic l, input logic b, input int len);
    return {e, l, b, RW'(len)};
  endfunction

  function automatic void exp_push(input logic [RW+2:0] t, input bit fresh = 1'b0);
    exp_t item;
    item.tok   = t;
    item.fresh = fresh;
    exp_q.push_back(item);
  endfunction

  // Monitor: samples mid-cycle, well clear of the rising edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (frame_done) begin
      fd_count++;
      fd_cycle = cyc;
    end
    if (err_abort) ab_count++;
    if (!rst && !bus.in_ready) rdy_low++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_token", 32'(bus.out_data), 32'hffff_ffff);
      end else begin
        cur_exp = exp_q.pop_front();
        check("token", 32'(bus.out_data), 32'(cur_exp.tok));
        if (cur_exp.fresh) line_sum = 0;
        line_sum += int'(bus.out_data[RW-1:LEN_LSB]);
        if (bus.out_data[EOF_B]) eof_pop_cycle = cyc;
        if (bus.out_data[EOL_B]) begin
          check("line_run_sum", 32'(line_sum), 32'(W));
          line_sum = 0;
        end
      end
    end
  end

  // Offers one pixel at a falling edge and holds it until accepted.
  task automatic send_px(input logic b, input logic sop);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_sop   = sop;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("px_accepted", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  // Sends eight pixels, leftmost character of the literal first.
  task automatic send_line(input logic [7:0] bits, input bit sop);
    for (int i = 7; i >= 0; i--) send_px(bits[i], sop && (i == 7));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0;
    int ab0;
    int rl0;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_sop    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_abort", 32'(err_abort), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // All-zero frame: one full-line token per line; eof visible one cycle
    // after the frame_done write.
    bus.out_ready = 1'b1;
    fd0 = fd_count;
    exp_push(tok(0, 1, 0, 8));
    exp_push(tok(1, 1, 0, 8));
    send_line(8'b0000_0000, 1'b1);
    send_line(8'b0000_0000, 1'b0);
    drain();
    check("zero_frame_done", 32'(fd_count - fd0), 32'd1);
    check("eof_latency", 32'(eof_pop_cycle), 32'(fd_cycle + 1));

    // Runs inside a line.
    fd0 = fd_count;
    exp_push(tok(0, 0, 0, 3));
    exp_push(tok(0, 0, 1, 3));
    exp_push(tok(0, 1, 0, 2));
    exp_push(tok(1, 1, 0, 8));
    send_line(8'b0001_1100, 1'b1);
    send_line(8'b0000_0000, 1'b0);
    drain();
    check("runs_frame_done", 32'(fd_count - fd0), 32'd1);

    // Bit change on the last pixel of both lines: split pairs, the second
    // one carrying eof.
    fd0 = fd_count;
    rl0 = rdy_low;
    exp_push(tok(0, 0, 0, 7));
    exp_push(tok(0, 1, 1, 1));
    exp_push(tok(0, 0, 1, 7));
    exp_push(tok(1, 1, 0, 1));
    send_line(8'b0000_0001, 1'b1);
    send_line(8'b1111_1110, 1'b0);
    drain();
    check("split_stall_cycles", 32'(rdy_low - rl0), 32'd2);
    check("split_frame_done", 32'(fd_count - fd0), 32'd1);

    // Alternating pixels with the consumer stalled: intake stops while
    // fewer than two entries are free.
    fd0 = fd_count;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) exp_push(tok(0, 0, i % 2, 1));
    exp_push(tok(0, 1, 1, 1));
    send_line(8'b0101_0101, 1'b1);
    idle(2);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("free1_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("free2_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) exp_push(tok(0, 0, i % 2, 1));
    exp_push(tok(1, 1, 1, 1));
    send_line(8'b0101_0101, 1'b0);
    drain();
    check("alt_frame_done", 32'(fd_count - fd0), 32'd1);

    // in_sop at x=5 of line 0 restarts the frame; buffered tokens survive.
    fd0 = fd_count;
    ab0 = ab_count;
    bus.out_ready = 1'b0;
    exp_push(tok(0, 0, 0, 2));
    exp_push(tok(0, 0, 1, 2));
    exp_push(tok(0, 1, 1, 8), 1'b1);
    exp_push(tok(1, 1, 1, 8));
    send_px(1'b0, 1'b1);
    send_px(1'b0, 1'b0);
    send_px(1'b1, 1'b0);
    send_px(1'b1, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) send_px(1'b1, 1'b0);
    send_line(8'b1111_1111, 1'b0);
    idle(2);
    check("abort_buffered_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    drain();
    check("abort_pulses", 32'(ab_count - ab0), 32'd1);
    check("abort_frame_done", 32'(fd_count - fd0), 32'd1);

    // Reset mid-line with three tokens buffered.
    bus.out_ready = 1'b0;
    send_px(1'b0, 1'b1);
    send_px(1'b1, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b1, 1'b0);
    idle(2);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    fd0 = fd_count;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_px(1'b1, 1'b0);
    idle(3);
    check("no_sop_ignored", 32'(bus.out_valid), 32'd0);
    exp_push(tok(0, 1, 1, 8), 1'b1);
    exp_push(tok(1, 1, 1, 8));
    send_line(8'b1111_1111, 1'b1);
    send_line(8'b1111_1111, 1'b0);
    drain();
    check("post_rst_frame_done", 32'(fd_count - fd0), 32'd1);

    check("total_frame_done", 32'(fd_count), 32'd6);
    check("total_abort", 32'(ab_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
